// File: rtl/pisa_loader_pkg.sv
// Shared types and frame constants for the boot-time code loader.
// Optional checksum support is controlled by CODE_LOADER_CHECKSUM_EN.
package pisa_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_LOAD   = 3'd2,
    S_CSUM   = 3'd3,
    S_RUN    = 3'd4,
    S_ERROR  = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERSIZE = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_CSUM     = 2'd3
  } loader_err_t;

  localparam int unsigned HDR_LEN  = 2;
  localparam int unsigned CSUM_LEN = 1;

  // States in which a stalled link is treated as an error.
  function automatic logic is_timed_state(input loader_state_t s);
    return (s == S_LEN_HI) || (s == S_LOAD) || (s == S_CSUM);
  endfunction

  // Total bytes on the wire for a frame carrying len payload bytes.
  function automatic int unsigned frame_bytes(input int unsigned len);
`ifdef CODE_LOADER_CHECKSUM_EN
    return HDR_LEN + len + CSUM_LEN;
`else
    return HDR_LEN + len;
`endif
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Restartable idle-cycle down-counter: expired is high once CYCLES enabled
// cycles have passed since the last clear.
module loader_timeout #(
  parameter int unsigned CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  // Loading CYCLES-1 makes expired visible during the CYCLES-th idle cycle.
  localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = RELOAD;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RELOAD;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/code_loader.sv
// Boot loader: parses LEN_LO, LEN_HI, payload [, CSUM] and writes code memory,
// holding the core in reset until an image is resident. Checksum: CODE_LOADER_CHECKSUM_EN.
module code_loader
  import pisa_loader_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_run,
  output logic              load_error,
  output logic [1:0]        err_code
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
`ifdef CODE_LOADER_CHECKSUM_EN
  localparam loader_state_t POST_PAYLOAD = S_CSUM;
`else
  localparam loader_state_t POST_PAYLOAD = S_RUN;
`endif

  loader_state_t     state_q, state_d;
  loader_err_t       err_q, err_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              core_run_q, core_run_d;
  logic              load_error_q, load_error_d;

  logic [15:0]       len_full;
  logic [ADDR_W:0]   cnt_inc;
  logic              timed;
  logic              tmo_clear;
  logic              tmo_expired;

  assign timed     = is_timed_state(state_q);
  assign tmo_clear = byte_valid | reload | ~timed;
  assign len_full  = {byte_data, len_lo_q};
  assign cnt_inc   = cnt_q + CNT_ONE;

  loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (timed),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
`ifdef CODE_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // reload beats both a stalled link and a byte arriving in the same cycle
    if (reload) begin
      state_d = S_LEN_LO;
      err_d   = ERR_NONE;
    end else if (timed && tmo_expired) begin
      state_d = S_ERROR;
      err_d   = ERR_TIMEOUT;
    end else if (byte_valid) begin
      case (state_q)
        S_LEN_LO: begin
          len_lo_d = byte_data;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          cnt_d = '0;
`ifdef CODE_LOADER_CHECKSUM_EN
          sum_d = 8'h00;
`endif
          len_d = (ADDR_W + 1)'(len_full);
          if (32'(len_full) > DEPTH) begin
            state_d = S_ERROR;
            err_d   = ERR_OVERSIZE;
          end else if (len_full == 16'h0000) begin
            state_d = POST_PAYLOAD;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = byte_data;
          cnt_d       = cnt_inc;
`ifdef CODE_LOADER_CHECKSUM_EN
          sum_d       = sum_q + byte_data;
`endif
          if (cnt_inc == len_q) begin
            state_d = POST_PAYLOAD;
          end
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (byte_data == sum_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_CSUM;
          end
        end
`endif
        default: ;
      endcase
    end

    core_run_d   = (state_d == S_RUN);
    load_error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LEN_LO;
      err_q        <= ERR_NONE;
      len_lo_q     <= 8'h00;
      len_q        <= '0;
      cnt_q        <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
      sum_q        <= 8'h00;
`endif
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
      core_run_q   <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
`ifdef CODE_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_run_q   <= core_run_d;
      load_error_q <= load_error_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_run   = core_run_q;
  assign load_error = load_error_q;
  assign err_code   = err_q;

endmodule
